// File: rtl/m3_pkg.sv
// m3_pkg: shared types, constants and helpers for the 3-phase PWM generator.
// Holds the FSM encoding, the Q8 sine table and the per-phase duty arithmetic.
package m3_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_PRE   = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } m3_state_e;

   localparam logic [9:0] POWER_MAX = 10'd1000;
   localparam logic [9:0] DUTY_HALF = 10'd500;

   function automatic logic signed [9:0] m3_sin(input logic [3:0] idx);
      logic signed [9:0] s;
      case (idx)
         4'd0:    s = 10'sd0;
         4'd1:    s = 10'sd128;
         4'd2:    s = 10'sd222;
         4'd3:    s = 10'sd256;
         4'd4:    s = 10'sd222;
         4'd5:    s = 10'sd128;
         4'd6:    s = 10'sd0;
         4'd7:    s = -10'sd128;
         4'd8:    s = -10'sd222;
         4'd9:    s = -10'sd256;
         4'd10:   s = -10'sd222;
         4'd11:   s = -10'sd128;
         default: s = 10'sd0;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] m3_idx(input logic [3:0] step,
                                         input logic [3:0] ofs);
      logic [4:0] t;
      t = {1'b0, step} + {1'b0, ofs};
      if (t >= 5'd12) t = t - 5'd12;
      return t[3:0];
   endfunction

   // 500 + ((P*sin) >>> 9); the shift floors, so negative halves round down
   function automatic logic [9:0] m3_duty(input logic [3:0] idx,
                                          input logic [9:0] pwr);
      logic signed [9:0]  s;
      logic signed [19:0] prod;
      logic signed [19:0] sum;
      s    = m3_sin(idx);
      prod = $signed({10'd0, pwr}) * $signed({{10{s[9]}}, s});
      sum  = (prod >>> 9) + 20'sd500;
      return sum[9:0];
   endfunction

endpackage

// File: rtl/m3_phase_pwm_gen_dead_time.sv
// m3_deadTime: converts one raw PWM bit into Hi/Lo gate drives with dead-time.
// Any raw edge (or enable rising) blanks both gates for DEAD_T clocks.
module m3_deadTime
   import m3_pkg::*;
#(
   parameter logic [3:0] DEAD_T = 4'd4
) (
   input  logic clkI,
   input  logic nRstI,
   input  logic en_i,
   input  logic raw_i,
   output logic hi_o,
   output logic lo_o
);

   logic       raw_q;
   logic       en_q;
   logic       hi_q;
   logic       lo_q;
   logic [3:0] cnt_q;
   logic       no_dt;

   assign no_dt = (DEAD_T == 4'd0);

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         raw_q <= 1'b0;
         en_q  <= 1'b0;
         hi_q  <= 1'b0;
         lo_q  <= 1'b0;
         cnt_q <= 4'd0;
      end else begin
         raw_q <= raw_i;
         en_q  <= en_i;
         if (!en_i) begin
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
            cnt_q <= 4'd0;
         end else if (!en_q || (raw_i != raw_q)) begin
            hi_q  <= no_dt & raw_i;
            lo_q  <= no_dt & ~raw_i;
            cnt_q <= no_dt ? 4'd0 : DEAD_T - 4'd1;
         end else if (cnt_q != 4'd0) begin
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
            cnt_q <= cnt_q - 4'd1;
         end else begin
            hi_q  <= raw_i;
            lo_q  <= ~raw_i;
         end
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/m3_phase_pwm_gen.sv
// m3_phase_pwm_gen: 3-phase sine-step PWM with bootstrap precharge and dead-time.
// Optional shoot-through checker is enabled by defining M3_SHOOT_THROUGH_CHECK_EN.
module m3_phase_pwm_gen
   import m3_pkg::*;
#(
   parameter logic [9:0]  PWM_TOP = 10'd999,
   parameter logic [3:0]  DEAD_T  = 4'd4,
   parameter logic [15:0] BOOT_T  = 16'd200
) (
   input  logic       clkI,
   input  logic       nRstI,
   input  logic       m3startI,
   input  logic       m3forceStopI,
   input  logic       m3invRotateI,
   input  logic [3:0] stepI,
   input  logic [9:0] powerI,
   output logic       uHiO,
   output logic       uLoO,
   output logic       vHiO,
   output logic       vLoO,
   output logic       wHiO,
   output logic       wLoO,
   output logic [1:0] stateO,
   output logic       carrierWrapO,
   output logic       errShootO
);

   m3_state_e       state_q;
   m3_state_e       state_d;
   logic [15:0]     boot_q;
   logic            pre_q;
   logic            fault_req;
   logic            run_d;
   logic            run_q;

   logic [9:0]      pwr;
   logic [3:0]      idx_v;
   logic [3:0]      idx_w;
   logic [2:0][9:0] duty_d;
   logic [2:0][9:0] duty_q;
   logic [2:0][9:0] shd_q;
   logic [9:0]      cnt_q;
   logic [2:0]      raw;
   logic [2:0]      hi;
   logic [2:0]      lo;

   // ---- FSM ----
   always_comb begin
      state_d = state_q;
      if (fault_req) begin
         state_d = ST_FAULT;
      end else if (!m3startI) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF:  state_d = ST_PRE;
            ST_PRE:  if (boot_q == BOOT_T - 16'd1) state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         state_q <= ST_OFF;
         boot_q  <= 16'd0;
         pre_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= (state_d == ST_PRE);
         if (state_q == ST_PRE && state_d == ST_PRE)
            boot_q <= boot_q + 16'd1;
         else
            boot_q <= 16'd0;
      end
   end

   assign run_d  = (state_d == ST_RUN);
   assign run_q  = (state_q == ST_RUN);
   assign stateO = state_q;

   // ---- duty calculation ----
   always_comb begin
      pwr   = (powerI > POWER_MAX) ? POWER_MAX : powerI;
      idx_v = m3invRotateI ? m3_idx(stepI, 4'd8) : m3_idx(stepI, 4'd4);
      idx_w = m3invRotateI ? m3_idx(stepI, 4'd4) : m3_idx(stepI, 4'd8);
      if (stepI > 4'd11) begin
         duty_d = {3{DUTY_HALF}};
      end else begin
         duty_d[0] = m3_duty(stepI, pwr);
         duty_d[1] = m3_duty(idx_v, pwr);
         duty_d[2] = m3_duty(idx_w, pwr);
      end
   end

   // ---- carrier and shadow duty ----
   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         duty_q <= {3{DUTY_HALF}};
         shd_q  <= {3{DUTY_HALF}};
         cnt_q  <= 10'd0;
      end else begin
         duty_q <= duty_d;
         if (!run_d) begin
            cnt_q <= 10'd0;
         end else if (!run_q || cnt_q == PWM_TOP) begin
            cnt_q <= 10'd0;
            shd_q <= duty_q;
         end else begin
            cnt_q <= cnt_q + 10'd1;
         end
      end
   end

   assign carrierWrapO = run_q && (cnt_q == PWM_TOP);

   always_comb begin
      raw = 3'b000;
      for (int i = 0; i < 3; i++) raw[i] = (cnt_q < shd_q[i]);
   end

   // Enable follows next state so RUN entry and gates share one latency
   for (genvar i = 0; i < 3; i++) begin : g_dt
      m3_deadTime #(
         .DEAD_T (DEAD_T)
      ) u_dt (
         .clkI  (clkI),
         .nRstI (nRstI),
         .en_i  (run_d),
         .raw_i (raw[i]),
         .hi_o  (hi[i]),
         .lo_o  (lo[i])
      );
   end

   assign uHiO = hi[0];
   assign vHiO = hi[1];
   assign wHiO = hi[2];
   assign uLoO = lo[0] | pre_q;
   assign vLoO = lo[1] | pre_q;
   assign wLoO = lo[2] | pre_q;

`ifdef M3_SHOOT_THROUGH_CHECK_EN
   logic shoot;
   logic err_q;

   assign shoot = (uHiO & uLoO) | (vHiO & vLoO) | (wHiO & wLoO);

   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI)
         err_q <= 1'b0;
      else if (state_d == ST_OFF && state_q != ST_OFF)
         err_q <= 1'b0;
      else if (shoot)
         err_q <= 1'b1;
   end

   assign fault_req = m3forceStopI | shoot;
   assign errShootO = err_q;
`else
   assign fault_req = m3forceStopI;
   assign errShootO = 1'b0;
`endif

endmodule
